// File: rtl/l1mtx_pkg.sv
// Shared encodings and types for the bus-matrix input stage.
// Holds the AHB HTRANS/HRESP codes, the input-stage state codes and the held-transfer record.
package l1mtx_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [1:0] ST_PASS = 2'b00;
  localparam logic [1:0] ST_HELD = 2'b01;
  localparam logic [1:0] ST_DATA = 2'b10;

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
  } ctrl_t;

  localparam ctrl_t CTRL_CLEAR = '{sel: 1'b0, addr: 32'h0000_0000, trans: HTRANS_IDLE,
                                   write: 1'b0, size: 3'b000, burst: 3'b000, prot: 4'b0000};

endpackage

// File: rtl/l1mtx_hold_reg.sv
// Holding register for an address phase the decoder could not accept.
// Captures the master's address/control on load and keeps it until the next load.
module l1mtx_hold_reg
  import l1mtx_pkg::*;
(
  input  logic  HCLK,
  input  logic  HRESETn,
  input  logic  load,
  input  ctrl_t d,
  output ctrl_t q
);

  ctrl_t ctrl_q;
  ctrl_t ctrl_d;

  // Next register value: capture on load, otherwise keep
  always_comb begin
    ctrl_d = ctrl_q;
    if (load) begin
      ctrl_d = d;
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Register storage with asynchronous clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_q <= CTRL_CLEAR;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign q = ctrl_q;

endmodule

// File: rtl/l1mtx_input_stage.sv
// AHB input stage for one bus-matrix slave port: passes transfers straight through,
// or holds an unaccepted address phase and stalls the master until it is issued.
module l1mtx_input_stage
  import l1mtx_pkg::*;
#(
  parameter logic CONV_SEQ = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic        HREADYS,
  output logic        HREADYOUTS,
  output logic [1:0]  HRESPS,
  input  logic        active_dec,
  input  logic        readyout_dec,
  input  logic [1:0]  resp_dec,
  output logic        sel_in,
  output logic [31:0] addr_in,
  output logic [1:0]  trans_in,
  output logic        write_in,
  output logic [2:0]  size_in,
  output logic [2:0]  burst_in,
  output logic [3:0]  prot_in,
  output logic        ready_in,
  output logic        held_tran
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       pend_s;
  logic       load_s;
  ctrl_t      cur_s;
  ctrl_t      held_s;

  assign pend_s = HSELS & HTRANSS[1] & HREADYS;

  assign cur_s = '{sel: HSELS, addr: HADDRS, trans: HTRANSS, write: HWRITES,
                   size: HSIZES, burst: HBURSTS, prot: HPROTS};

  l1mtx_hold_reg u_hold_reg (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .load    (load_s),
    .d       (cur_s),
    .q       (held_s)
  );

  // Next-state and hold-register load decision
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    case (state_q)
      ST_PASS: begin
        if (pend_s && !active_dec) begin
          load_s  = 1'b1;
          state_d = ST_HELD;
        end else begin
          state_d = ST_PASS;
        end
      end
      ST_HELD: begin
        if (active_dec) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_HELD;
        end
      end
      ST_DATA: begin
        // Released transfer completes; a newly blocked one reloads with no gap
        if (readyout_dec) begin
          if (pend_s && !active_dec) begin
            load_s  = 1'b1;
            state_d = ST_HELD;
          end else begin
            state_d = ST_PASS;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_PASS;
      end
    endcase
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_PASS;
    end else begin
      state_q <= state_d;
    end
  end

  // Output mux: held register while stalled, live master signals otherwise
  always_comb begin
    sel_in     = HSELS;
    addr_in    = HADDRS;
    trans_in   = HTRANSS;
    write_in   = HWRITES;
    size_in    = HSIZES;
    burst_in   = HBURSTS;
    prot_in    = HPROTS;
    ready_in   = HREADYS;
    HREADYOUTS = readyout_dec;
    HRESPS     = resp_dec;
    held_tran  = 1'b0;
    if (state_q == ST_HELD) begin
      sel_in     = held_s.sel;
      addr_in    = held_s.addr;
      write_in   = held_s.write;
      size_in    = held_s.size;
      burst_in   = held_s.burst;
      prot_in    = held_s.prot;
      ready_in   = 1'b1;
      HREADYOUTS = 1'b0;
      HRESPS     = HRESP_OKAY;
      held_tran  = 1'b1;
      if (CONV_SEQ && (held_s.trans == HTRANS_SEQ)) begin
        trans_in = HTRANS_NONSEQ;
      end else begin
        trans_in = held_s.trans;
      end
    end else begin
      held_tran = 1'b0;
    end
  end

endmodule

// File: tb/tb_l1mtx_input_stage.sv
// Directed bench for l1mtx_input_stage: a transfer-level model is checked every cycle,
// and literal expectations at key points pin the model.
module tb_l1mtx_input_stage;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSELS = 1'b0;
  logic [31:0] HADDRS = 32'h0;
  logic [1:0]  HTRANSS = 2'b00;
  logic        HWRITES = 1'b0;
  logic [2:0]  HSIZES = 3'b000;
  logic [2:0]  HBURSTS = 3'b000;
  logic [3:0]  HPROTS = 4'h0;
  logic        HREADYS = 1'b1;
  logic        active_dec = 1'b1;
  logic        readyout_dec = 1'b1;
  logic [1:0]  resp_dec = 2'b00;

  logic        HREADYOUTS, sel_in, write_in, ready_in, held_tran;
  logic [1:0]  HRESPS, trans_in;
  logic [31:0] addr_in;
  logic [2:0]  size_in, burst_in;
  logic [3:0]  prot_in;

  logic        HREADYOUTS0, sel_in0, write_in0, ready_in0, held_tran0;
  logic [1:0]  HRESPS0, trans_in0;
  logic [31:0] addr_in0;
  logic [2:0]  size_in0, burst_in0;
  logic [3:0]  prot_in0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  l1mtx_input_stage #(.CONV_SEQ(1'b1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HREADYS(HREADYS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .active_dec(active_dec),
    .readyout_dec(readyout_dec), .resp_dec(resp_dec), .sel_in(sel_in), .addr_in(addr_in),
    .trans_in(trans_in), .write_in(write_in), .size_in(size_in), .burst_in(burst_in),
    .prot_in(prot_in), .ready_in(ready_in), .held_tran(held_tran)
  );

  l1mtx_input_stage #(.CONV_SEQ(1'b0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HREADYS(HREADYS),
    .HREADYOUTS(HREADYOUTS0), .HRESPS(HRESPS0), .active_dec(active_dec),
    .readyout_dec(readyout_dec), .resp_dec(resp_dec), .sel_in(sel_in0), .addr_in(addr_in0),
    .trans_in(trans_in0), .write_in(write_in0), .size_in(size_in0), .burst_in(burst_in0),
    .prot_in(prot_in0), .ready_in(ready_in0), .held_tran(held_tran0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Transfer-level model: is a transfer parked, and is a released one still in its data phase
  bit          m_holding = 1'b0;
  bit          m_wait = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [1:0]  m_trans = 2'b00;
  logic        m_write = 1'b0;
  logic [2:0]  m_size = 3'b000;
  logic [2:0]  m_burst = 3'b000;
  logic [3:0]  m_prot = 4'h0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_holding <= 1'b0;
      m_wait <= 1'b0;
    end else if (m_holding) begin
      if (active_dec) begin
        m_holding <= 1'b0;
        m_wait <= 1'b1;
      end
    end else if (!m_wait || readyout_dec) begin
      m_wait <= 1'b0;
      if (HSELS && HTRANSS[1] && HREADYS && !active_dec) begin
        m_holding <= 1'b1;
        m_addr <= HADDRS;
        m_trans <= HTRANSS;
        m_write <= HWRITES;
        m_size <= HSIZES;
        m_burst <= HBURSTS;
        m_prot <= HPROTS;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge HCLK) begin
    if (m_holding) begin
      chk("m_sel", {31'h0, sel_in}, 32'h1);
      chk("m_addr", addr_in, m_addr);
      chk("m_trans_c1", {30'h0, trans_in}, {30'h0, (m_trans == 2'b11) ? 2'b10 : m_trans});
      chk("m_trans_c0", {30'h0, trans_in0}, {30'h0, m_trans});
      chk("m_ctl", {20'h0, write_in, size_in, burst_in, prot_in},
          {20'h0, m_write, m_size, m_burst, m_prot});
      chk("m_rdy_in", {31'h0, ready_in}, 32'h1);
      chk("m_rdyout", {31'h0, HREADYOUTS}, 32'h0);
      chk("m_resp", {30'h0, HRESPS}, 32'h0);
      chk("m_held", {31'h0, held_tran}, 32'h1);
    end else begin
      chk("m_sel", {31'h0, sel_in}, {31'h0, HSELS});
      chk("m_addr", addr_in, HADDRS);
      chk("m_trans_c1", {30'h0, trans_in}, {30'h0, HTRANSS});
      chk("m_trans_c0", {30'h0, trans_in0}, {30'h0, HTRANSS});
      chk("m_ctl", {20'h0, write_in, size_in, burst_in, prot_in},
          {20'h0, HWRITES, HSIZES, HBURSTS, HPROTS});
      chk("m_rdy_in", {31'h0, ready_in}, {31'h0, HREADYS});
      chk("m_rdyout", {31'h0, HREADYOUTS}, {31'h0, readyout_dec});
      chk("m_resp", {30'h0, HRESPS}, {30'h0, resp_dec});
      chk("m_held", {31'h0, held_tran}, 32'h0);
    end
    chk("m_held_c0", {31'h0, held_tran0}, {31'h0, held_tran});
  end

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drv(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                     input logic wr, input logic act, input logic rdy, input logic [1:0] rsp,
                     input logic hrdy);
    HSELS = sel;
    HADDRS = addr;
    HTRANSS = trans;
    HWRITES = wr;
    HSIZES = 3'b010;
    HBURSTS = 3'b001;
    HPROTS = 4'b0011;
    active_dec = act;
    readyout_dec = rdy;
    resp_dec = rsp;
    HREADYS = hrdy;
  endtask

  initial begin
    // Reset state
    nxt();
    @(negedge HCLK);
    chk("rst_held", {31'h0, held_tran}, 32'h0);
    chk("rst_rdyout", {31'h0, HREADYOUTS}, 32'h1);
    chk("rst_resp", {30'h0, HRESPS}, 32'h0);
    chk("rst_sel", {31'h0, sel_in}, 32'h0);
    chk("rst_trans", {30'h0, trans_in}, 32'h0);
    nxt();
    HRESETn = 1'b1;

    // Straight pass-through, zero latency
    drv(1'b1, 32'h2000_0010, 2'b10, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1);
    @(negedge HCLK);
    chk("pass_addr", addr_in, 32'h2000_0010);
    chk("pass_held", {31'h0, held_tran}, 32'h0);
    chk("pass_rdyout", {31'h0, HREADYOUTS}, 32'h1);
    nxt();
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    @(negedge HCLK);
    chk("pass_rdyout_lo", {31'h0, HREADYOUTS}, 32'h0);
    nxt();
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1);
    nxt();

    // Blocked NONSEQ read: three stall cycles, then issue
    drv(1'b1, 32'h4001_0004, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
    nxt();
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
      @(negedge HCLK);
      chk("hold_held", {31'h0, held_tran}, 32'h1);
      chk("hold_rdyout", {31'h0, HREADYOUTS}, 32'h0);
      chk("hold_addr", addr_in, 32'h4001_0004);
      nxt();
    end
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
    @(negedge HCLK);
    chk("issue_addr", addr_in, 32'h4001_0004);
    chk("issue_trans", {30'h0, trans_in}, 32'h2);
    nxt();
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    @(negedge HCLK);
    chk("data_held", {31'h0, held_tran}, 32'h0);
    chk("data_rdyout", {31'h0, HREADYOUTS}, 32'h0);
    nxt();
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1);
    nxt();

    // Held SEQ, then ERROR response in the data phase
    drv(1'b1, 32'h4001_0008, 2'b11, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
    nxt();
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    @(negedge HCLK);
    chk("seq_conv1", {30'h0, trans_in}, 32'h2);
    chk("seq_conv0", {30'h0, trans_in0}, 32'h3);
    nxt();
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
    nxt();
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    @(negedge HCLK);
    chk("err1_resp", {30'h0, HRESPS}, 32'h1);
    chk("err1_rdyout", {31'h0, HREADYOUTS}, 32'h0);
    nxt();
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1);
    @(negedge HCLK);
    chk("err2_resp", {30'h0, HRESPS}, 32'h1);
    chk("err2_rdyout", {31'h0, HREADYOUTS}, 32'h1);
    nxt();
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1);
    @(negedge HCLK);
    chk("err_pass_held", {31'h0, held_tran}, 32'h0);
    nxt();

    // Reset while holding
    drv(1'b1, 32'h3000_0000, 2'b10, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
    nxt();
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    @(negedge HCLK);
    chk("prerst_held", {31'h0, held_tran}, 32'h1);
    nxt();
    HRESETn = 1'b0;
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1);
    @(negedge HCLK);
    chk("midrst_held", {31'h0, held_tran}, 32'h0);
    chk("midrst_rdyout", {31'h0, HREADYOUTS}, 32'h1);
    chk("midrst_trans", {30'h0, trans_in}, 32'h0);
    nxt();
    HRESETn = 1'b1;
    nxt();

    // Back-to-back: next blocked transfer reloads as the released one completes
    drv(1'b1, 32'h5000_0000, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
    nxt();
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
    nxt();
    drv(1'b1, 32'h6000_0040, 2'b10, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
    @(negedge HCLK);
    chk("b2b_data_addr", addr_in, 32'h6000_0040);
    chk("b2b_data_held", {31'h0, held_tran}, 32'h0);
    nxt();
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    @(negedge HCLK);
    chk("b2b_held", {31'h0, held_tran}, 32'h1);
    chk("b2b_addr", addr_in, 32'h6000_0040);
    chk("b2b_rdyout", {31'h0, HREADYOUTS}, 32'h0);
    nxt();
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
    nxt();
    drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1);
    nxt();
    nxt();
    @(negedge HCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l1mtx_input_stage.md
# l1mtx_input_stage

AHB slave-port input stage for one bus-matrix input (S3). It sits between the external master port and the S3 address decoder. A transfer whose address phase the decoder cannot accept (target output stage not active) is captured in a holding register, and the master is stalled until the held transfer is issued downstream. Read data and read user data bypass this block.

## Interface
Parameters:
- CONV_SEQ, 1, when 1 a held SEQ transfer is issued downstream as NONSEQ (burst broken by arbitration); when 0 it is issued unchanged.

Ports:
- HCLK  in  1  AHB clock; reset HRESETn, asynchronous, active-low; clock HCLK.
- HRESETn  in  1  async active-low reset.
- HSELS  in  1  master-port select.
- HADDRS  in  32  master address.
- HTRANSS  in  2  master HTRANS.
- HWRITES  in  1  master HWRITE.
- HSIZES  in  3  master HSIZE.
- HBURSTS  in  3  master HBURST.
- HPROTS  in  4  master HPROT.
- HREADYS  in  1  master-port HREADY (bus ready).
- HREADYOUTS  out  1  ready returned to master.
- HRESPS  out  2  response returned to master.
- active_dec  in  1  decoder: target output stage active for current address.
- readyout_dec  in  1  decoder HREADYOUTS.
- resp_dec  in  2  decoder HRESPS.
- sel_in  out  1  select to decoder.
- addr_in  out  32  address to decoder; the decoder uses [31:10].
- trans_in, write_in, size_in, burst_in, prot_in  out  2/1/3/3/4  control to decoder.
- ready_in  out  1  HREADY to decoder.
- held_tran  out  1  high while the held transfer is presented.

## Operation
- Pending transfer: pend = HSELS & HTRANSS[1] & HREADYS.
- FSM states:
  - PASS (reset state). Address/control outputs mirror master inputs. ready_in = HREADYS. HREADYOUTS = readyout_dec. HRESPS = resp_dec.
    - pend & ~active_dec: load holding register (sel, addr, trans, write, size, burst, prot), go to HELD.
  - HELD. Outputs driven from the register; sel_in = 1; held_tran = 1. trans_in = NONSEQ if CONV_SEQ & reg_trans == SEQ, else reg_trans. ready_in = 1 (no downstream data phase outstanding). HREADYOUTS = 0 and HRESPS = OKAY, stalling the master in the data phase of the held transfer.
    - active_dec = 1: held address phase is accepted this cycle; go to DATA.
  - DATA. Outputs mirror master inputs (the master's next address is live). ready_in = HREADYS. HREADYOUTS = readyout_dec. HRESPS = resp_dec.
    - Next state is PASS when readyout_dec = 1. The PASS load rule applies in the same cycle if pend & ~active_dec.
- IDLE/BUSY master transfers never load the register.
- ERROR two-cycle response passes through unchanged in PASS and DATA.

## Timing
- Reset values:
  - State PASS.
  - Register cleared: addr 0, trans IDLE, control 0.
  - held_tran = 0, HREADYOUTS = 1, HRESPS = OKAY. In PASS with idle inputs, sel_in = 0.
- Pass-through path is combinational, with zero added latency when active_dec = 1.
- Held transfer adds at least 1 stall cycle. It is issued on the first cycle in HELD with active_dec = 1, and its data phase starts the next cycle.
- Reset asserted mid-HELD or mid-DATA: immediate return to PASS and discard the held transfer.
- active_dec toggling while in HELD has no effect on the register contents.

## Structure
- Shared package l1mtx_pkg:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - HRESP OKAY/ERROR.
  - Input-stage state encoding.
- One natural sub-module, l1mtx_hold_reg: the holding register with load enable and async reset.

## Test plan
- PASS, active_dec = 1, NONSEQ write to 0x20000010 -> addr_in = 0x20000010 in the same cycle; held_tran = 0; HREADYOUTS follows readyout_dec.
- NONSEQ read to 0x40010004 with active_dec = 0 for 3 cycles -> held_tran = 1; HREADYOUTS = 0 for those 3 cycles; addr_in held at 0x40010004; DATA entered the cycle after active_dec rises.
- Held SEQ with CONV_SEQ = 1 -> trans_in = 2'b10. Repeat with CONV_SEQ = 0 -> trans_in = 2'b11.
- Decoder returns ERROR in DATA (two cycles: readyout_dec 0 then 1) -> HRESPS = ERROR both cycles; HREADYOUTS 0 then 1; return to PASS.
- HRESETn asserted in HELD -> next cycle held_tran = 0, HREADYOUTS = 1, trans_in = IDLE.
- Back-to-back: held transfer released, next master NONSEQ also blocked (active_dec = 0) as DATA completes -> immediate reload to HELD with no idle cycle.
